// File: rtl/alu.sv
// Single-cycle 32-bit integer ALU with a registered result and zero flag.
// Operands and opcode are sampled on every rising CLK edge; unused opcodes yield zero.
module alu #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    input  logic [OPRN_WIDTH-1:0] OPRN,
    output logic [DATA_WIDTH-1:0] OUT,
    output logic                  ZERO
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

    logic [DATA_WIDTH-1:0]  out_q;
    logic [DATA_WIDTH-1:0]  out_d;
    logic                   zero_q;
    logic                   zero_d;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   shift_overrange;
    logic [DATA_WIDTH-1:0]  srl_res;
    logic [DATA_WIDTH-1:0]  sll_res;
    logic                   slt_bit;

    // Any set bit above the in-range shift amount means the whole operand shifts out.
    assign shamt           = OP2[SHAMT_WIDTH-1:0];
    assign shift_overrange = |OP2[DATA_WIDTH-1:SHAMT_WIDTH];
    assign srl_res         = shift_overrange ? '0 : (OP1 >> shamt);
    assign sll_res         = shift_overrange ? '0 : (OP1 << shamt);
    assign slt_bit         = $signed(OP1) < $signed(OP2);

    always_comb begin
        out_d = '0;
        case (OPRN)
            OP_ADD:  out_d = OP1 + OP2;
            OP_SUB:  out_d = OP1 - OP2;
            OP_MUL:  out_d = OP1 * OP2;
            OP_SRL:  out_d = srl_res;
            OP_SLL:  out_d = sll_res;
            OP_AND:  out_d = OP1 & OP2;
            OP_OR:   out_d = OP1 | OP2;
            OP_NOR:  out_d = ~(OP1 | OP2);
            OP_SLT:  out_d = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
            default: out_d = '0;
        endcase
    end

    // Flag is derived from the same next value so it never lags the result.
    assign zero_d = (out_d == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            out_q  <= out_d;
            zero_q <= zero_d;
        end
    end

    assign OUT  = out_q;
    assign ZERO = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the alu: reset behaviour, every opcode, boundary cases
// and back-to-back opcode changes, each result checked one edge after it is applied.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  oprn;
    logic [31:0] out;
    logic        zero;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [5:0]  oprn;
        logic [31:0] exp_out;
        logic        exp_zero;
        string       name;
    } vec_t;

    vec_t vecs[$];

    alu #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
        .CLK  (clk),
        .RST  (rst),
        .OP1  (op1),
        .OP2  (op2),
        .OPRN (oprn),
        .OUT  (out),
        .ZERO (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] exp_out, input logic exp_zero);
        tests_run++;
        if (out !== exp_out || zero !== exp_zero) begin
            tests_failed++;
            $display("[TB] FAIL %s: got OUT=%08h ZERO=%b, expected OUT=%08h ZERO=%b",
                     name, out, zero, exp_out, exp_zero);
        end else begin
            $display("[TB] ok   %s: OUT=%08h ZERO=%b", name, out, zero);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then look 1 time unit later.
    task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op);
        rst  = r;
        op1  = a;
        op2  = b;
        oprn = op;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                           input logic [31:0] eo, input logic ez, input string name);
        vec_t v;
        v.op1 = a; v.op2 = b; v.oprn = op;
        v.exp_out = eo; v.exp_zero = ez; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst  = 1'b1;
        op1  = 32'd5;
        op2  = 32'd5;
        oprn = 6'd1;

        // Arithmetic
        add_vec(32'hFFFF_FFF4, 32'd15,        6'd1, 32'd3,         1'b0, "add -12+15");
        add_vec(32'd100,       32'd79,        6'd2, 32'd21,        1'b0, "sub 100-79");
        add_vec(32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'd3, 32'd2,         1'b0, "mul -2*-1");
        add_vec(32'h7FFF_FFFF, 32'd1,         6'd1, 32'h8000_0000, 1'b0, "add max+1");
        add_vec(32'd0,         32'd1,         6'd2, 32'hFFFF_FFFF, 1'b0, "sub 0-1");
        add_vec(32'h0001_0000, 32'h0001_0000, 6'd3, 32'd0,         1'b1, "mul wrap");
        add_vec(32'd7,         32'd7,         6'd2, 32'd0,         1'b1, "sub equal");
        // Shifts
        add_vec(32'd15,        32'd2,         6'd4, 32'd3,         1'b0, "srl 15>>2");
        add_vec(32'd2,         32'd1,         6'd5, 32'd4,         1'b0, "sll 2<<1");
        add_vec(32'h8000_0000, 32'd31,        6'd4, 32'd1,         1'b0, "srl msb>>31");
        add_vec(32'd1,         32'd32,        6'd5, 32'd0,         1'b1, "sll 1<<32");
        add_vec(32'hFFFF_FFFF, 32'd4,         6'd4, 32'h0FFF_FFFF, 1'b0, "srl ones>>4");
        add_vec(32'hDEAD_BEEF, 32'd0,         6'd5, 32'hDEAD_BEEF, 1'b0, "sll by 0");
        add_vec(32'hDEAD_BEEF, 32'd0,         6'd4, 32'hDEAD_BEEF, 1'b0, "srl by 0");
        add_vec(32'hFFFF_FFFF, 32'h0000_0021, 6'd4, 32'd0,         1'b1, "srl by 33");
        add_vec(32'd1,         32'h8000_0001, 6'd5, 32'd0,         1'b1, "sll huge amt");
        add_vec(32'd1,         32'd31,        6'd5, 32'h8000_0000, 1'b0, "sll 1<<31");
        // Logic
        add_vec(32'd6,         32'd10,        6'd6, 32'd2,         1'b0, "and 6&10");
        add_vec(32'd2,         32'd1,         6'd7, 32'd3,         1'b0, "or 2|1");
        add_vec(32'd15,        32'd5,         6'd8, 32'hFFFF_FFF0, 1'b0, "nor 15,5");
        add_vec(32'hFFFF_FFFF, 32'd0,         6'd8, 32'd0,         1'b1, "nor -1,0");
        // Set-less-than
        add_vec(32'd2,         32'hFFFF_FFFF, 6'd9, 32'd0,         1'b1, "slt 2,-1");
        add_vec(32'hFFFF_FFFF, 32'd2,         6'd9, 32'd1,         1'b0, "slt -1,2");
        add_vec(32'd7,         32'd7,         6'd9, 32'd0,         1'b1, "slt 7,7");
        add_vec(32'h8000_0000, 32'd0,         6'd9, 32'd1,         1'b0, "slt min,0");
        add_vec(32'h7FFF_FFFF, 32'h8000_0000, 6'd9, 32'd0,         1'b1, "slt max,min");
        // Illegal opcodes
        add_vec(32'd0,         32'd0,         6'd10, 32'd0,        1'b1, "illegal 10");
        add_vec(32'd69,        32'd420,       6'd0,  32'd0,        1'b1, "illegal 0");
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 32'd0,        1'b1, "illegal 63");
        add_vec(32'd3,         32'd4,         6'd1,  32'd7,        1'b0, "add after illegal");

        // Reset held for two cycles with a live add on the inputs
        apply(1'b1, 32'd5, 32'd5, 6'd1);
        check("reset cycle 1", 32'd0, 1'b1);
        apply(1'b1, 32'd5, 32'd5, 6'd1);
        check("reset cycle 2", 32'd0, 1'b1);
        apply(1'b0, 32'd5, 32'd5, 6'd1);
        check("first after reset", 32'd10, 1'b0);

        // Table, one vector per cycle so the opcode changes on every edge
        for (int i = 0; i < vecs.size(); i++) begin
            apply(1'b0, vecs[i].op1, vecs[i].op2, vecs[i].oprn);
            check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_zero);
        end

        // Reset asserted mid-stream overrides a nonzero result, then recovery
        apply(1'b0, 32'd40, 32'd2, 6'd1);
        check("pre mid-reset add", 32'd42, 1'b0);
        apply(1'b1, 32'd40, 32'd2, 6'd1);
        check("mid-stream reset", 32'd0, 1'b1);
        apply(1'b0, 32'd9, 32'd3, 6'd2);
        check("sub after mid-reset", 32'd6, 1'b0);

        // Hold the same inputs: the result must be stable, then follow a single change
        apply(1'b0, 32'd9, 32'd3, 6'd2);
        check("held inputs", 32'd6, 1'b0);
        apply(1'b0, 32'd9, 32'd3, 6'd3);
        check("opcode change only", 32'd27, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends, reporting the overrun as a failure
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
